// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master clock generator.
package spi_master_pkg;

    // Clock generator state: idle (clock parked low), running, or draining to a low park.
    typedef enum logic [1:0] {
        CG_IDLE  = 2'd0,
        CG_RUN   = 2'd1,
        CG_DRAIN = 2'd2
    } clkgen_state_t;

    // Default divider width: half SPI period is clk_div+1 system clocks.
    localparam int unsigned SPI_CLKDIV_W = 8;

endpackage

// File: rtl/spi_master_clkgen.sv
// SPI serial clock generator with edge strobes, safe low-level stop and deferred divider update.
module spi_master_clkgen
    import spi_master_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = SPI_CLKDIV_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic                 clk_div_valid,
    output logic                 spi_clk,
    output logic                 spi_rise,
    output logic                 spi_fall,
    output logic                 running
);

    clkgen_state_t        state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_reg_q, div_reg_d;
    logic [DIV_WIDTH-1:0] div_shadow_q, div_shadow_d;
    logic                 div_pending_q, div_pending_d;
    logic                 spi_clk_q, spi_clk_d;

    logic toggle;
    logic enter_idle;

    // Half-period boundary: only meaningful while the clock is active.
    always_comb begin
        toggle = (state_q != CG_IDLE) && (cnt_q == div_reg_q);
    end

    // Next-state logic for the FSM, half-period counter, clock level and divider registers.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        spi_clk_d     = spi_clk_q;
        div_reg_d     = div_reg_q;
        div_shadow_d  = div_shadow_q;
        div_pending_d = div_pending_q;

        unique case (state_q)
            CG_IDLE: begin
                cnt_d     = '0;
                spi_clk_d = 1'b0;
                if (en) begin
                    state_d = CG_RUN;
                end
            end
            CG_RUN, CG_DRAIN: begin
                if (toggle) begin
                    cnt_d     = '0;
                    spi_clk_d = ~spi_clk_q;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end

                if (en) begin
                    // Re-enable during drain resumes without touching the counter.
                    state_d = CG_RUN;
                end else if (!spi_clk_q && !toggle) begin
                    // Parked low with nothing due: stop immediately.
                    state_d = CG_IDLE;
                    cnt_d   = '0;
                end else if (toggle && spi_clk_q) begin
                    // The falling edge completes the high phase; clock ends low.
                    state_d = CG_IDLE;
                end else begin
                    // High phase in progress or a rise is due: finish it before stopping.
                    state_d = CG_DRAIN;
                end
            end
            default: begin
                state_d   = CG_IDLE;
                cnt_d     = '0;
                spi_clk_d = 1'b0;
            end
        endcase

        enter_idle = (state_q != CG_IDLE) && (state_d == CG_IDLE);

        if (state_q == CG_IDLE) begin
            if (clk_div_valid) begin
                div_reg_d = clk_div;
            end
        end else if (enter_idle) begin
            // A strobe arriving on the idle-entry cycle beats any older pending value.
            if (clk_div_valid) begin
                div_reg_d = clk_div;
            end else if (div_pending_q) begin
                div_reg_d = div_shadow_q;
            end
            div_pending_d = 1'b0;
        end else if (clk_div_valid) begin
            div_shadow_d  = clk_div;
            div_pending_d = 1'b1;
        end
    end

    // State and datapath registers; reset parks the clock low at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= CG_IDLE;
            cnt_q         <= '0;
            spi_clk_q     <= 1'b0;
            div_reg_q     <= '0;
            div_shadow_q  <= '0;
            div_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            spi_clk_q     <= spi_clk_d;
            div_reg_q     <= div_reg_d;
            div_shadow_q  <= div_shadow_d;
            div_pending_q <= div_pending_d;
        end
    end

    // Outputs: strobes mark the cycle whose closing edge moves spi_clk.
    always_comb begin
        spi_clk  = spi_clk_q;
        spi_rise = toggle & ~spi_clk_q;
        spi_fall = toggle & spi_clk_q;
        running  = (state_q != CG_IDLE);
    end

endmodule

// File: tb/tb_spi_master_clkgen.sv
// Self-checking bench: strobe scoreboard plus per-scenario level checks.
module tb_spi_master_clkgen;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic [DW-1:0] clk_div;
    logic          clk_div_valid;
    logic          spi_clk;
    logic          spi_rise;
    logic          spi_fall;
    logic          running;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int n_rise = 0;
    int n_fall = 0;

    typedef struct {
        int cyc;
        bit rise;
    } strobe_t;

    strobe_t exp_q[$];
    strobe_t mon_e;

    spi_master_clkgen #(.DIV_WIDTH(DW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .en           (en),
        .clk_div      (clk_div),
        .clk_div_valid(clk_div_valid),
        .spi_clk      (spi_clk),
        .spi_rise     (spi_rise),
        .spi_fall     (spi_fall),
        .running      (running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every observed strobe must match the next expected one in cycle and direction.
    always @(negedge clk) begin
        if (spi_rise) n_rise++;
        if (spi_fall) n_fall++;
        if (spi_rise || spi_fall) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: cyc=%0d rise=%b fall=%b, required no strobe",
                         cyc, spi_rise, spi_fall);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc !== mon_e.cyc || spi_rise !== mon_e.rise || spi_fall !== !mon_e.rise) begin
                    n_fail++;
                    $display("FAIL strobe_match: got cyc=%0d rise=%b fall=%b, required cyc=%0d rise=%b",
                             cyc, spi_rise, spi_fall, mon_e.cyc, mon_e.rise);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Strobe j of a run started at cycle s lands at s+(j+1)*(d+1); even j are rises.
    task automatic push_strobes(input int s, input int d, input int j0, input int n);
        for (int j = j0; j < j0 + n; j++) begin
            strobe_t e;
            e.cyc  = s + (j + 1) * (d + 1);
            e.rise = (j % 2 == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({spi_clk, running, spi_rise, spi_fall} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 0000",
                     {spi_clk, running, spi_rise, spi_fall});
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({spi_clk, running} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b, required 00", {spi_clk, running});
        end
    endtask

    task automatic test_div0();
        int s;
        int r0;
        int f0;
        s  = cyc;
        r0 = n_rise;
        f0 = n_fall;
        clk_div = 8'd0;
        clk_div_valid = 1'b1;
        en = 1'b1;
        push_strobes(s, 0, 0, 10);
        @(negedge clk);
        clk_div_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            wait_cyc(s + k);
            n_tests++;
            if (spi_clk !== (k % 2 == 0)) begin
                n_fail++;
                $display("FAIL div0_level k=%0d: got %b, required %b", k, spi_clk, (k % 2 == 0));
            end
        end
        n_tests++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL div0_running_before_stop: got %b, required 1", running);
        end
        en = 1'b0;
        wait_cyc(s + 11);
        n_tests++;
        if ({running, spi_clk} !== 2'b00) begin
            n_fail++;
            $display("FAIL div0_stop: got running,spi_clk=%b, required 00", {running, spi_clk});
        end
        wait_cyc(s + 12);
        n_tests++;
        if (n_rise - r0 != 5 || n_fall - f0 != 5) begin
            n_fail++;
            $display("FAIL div0_counts: got rise=%0d fall=%0d, required 5 and 5",
                     n_rise - r0, n_fall - f0);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL div0_missing: %0d strobes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_div3();
        int s;
        s = cyc;
        clk_div = 8'd3;
        clk_div_valid = 1'b1;
        en = 1'b1;
        push_strobes(s, 3, 0, 8);
        @(negedge clk);
        clk_div_valid = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            wait_cyc(s + k);
            n_tests++;
            if (spi_clk !== (((k - 1) / 4) % 2 == 1)) begin
                n_fail++;
                $display("FAIL div3_level k=%0d: got %b, required %b",
                         k, spi_clk, (((k - 1) / 4) % 2 == 1));
            end
        end
        wait_cyc(s + 33);
        en = 1'b0;
        wait_cyc(s + 34);
        n_tests++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL div3_stop_low: got running=%b, required 0", running);
        end
        wait_cyc(s + 35);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL div3_missing: %0d strobes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_drain();
        int s;
        s = cyc;
        en = 1'b1;
        push_strobes(s, 3, 0, 2);
        wait_cyc(s + 6);
        en = 1'b0;
        wait_cyc(s + 7);
        n_tests++;
        if ({running, spi_clk} !== 2'b11) begin
            n_fail++;
            $display("FAIL drain_enter: got running,spi_clk=%b, required 11", {running, spi_clk});
        end
        wait_cyc(s + 8);
        n_tests++;
        if ({running, spi_clk} !== 2'b11) begin
            n_fail++;
            $display("FAIL drain_hold_high: got running,spi_clk=%b, required 11", {running, spi_clk});
        end
        wait_cyc(s + 9);
        n_tests++;
        if ({running, spi_clk} !== 2'b00) begin
            n_fail++;
            $display("FAIL drain_exit: got running,spi_clk=%b, required 00", {running, spi_clk});
        end
        wait_cyc(s + 14);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_missing: %0d strobes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_div_update();
        int s;
        int s2;
        s = cyc;
        clk_div = 8'd2;
        clk_div_valid = 1'b1;
        en = 1'b1;
        push_strobes(s, 2, 0, 6);
        @(negedge clk);
        clk_div_valid = 1'b0;
        wait_cyc(s + 5);
        clk_div = 8'd5;
        clk_div_valid = 1'b1;
        @(negedge clk);
        clk_div_valid = 1'b0;
        wait_cyc(s + 19);
        en = 1'b0;
        wait_cyc(s + 20);
        n_tests++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL divupd_stop: got running=%b, required 0", running);
        end
        wait_cyc(s + 21);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL divupd_old_missing: %0d strobes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        s2 = cyc;
        en = 1'b1;
        push_strobes(s2, 5, 0, 4);
        wait_cyc(s2 + 6);
        n_tests++;
        if (spi_clk !== 1'b0) begin
            n_fail++;
            $display("FAIL divupd_low6: got %b, required 0", spi_clk);
        end
        wait_cyc(s2 + 12);
        n_tests++;
        if (spi_clk !== 1'b1) begin
            n_fail++;
            $display("FAIL divupd_high6: got %b, required 1", spi_clk);
        end
        wait_cyc(s2 + 25);
        en = 1'b0;
        wait_cyc(s2 + 27);
        n_tests++;
        if (exp_q.size() != 0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL divupd_new: outstanding=%0d running=%b, required 0 and 0",
                     exp_q.size(), running);
            exp_q.delete();
        end
    endtask

    task automatic test_simultaneous();
        int s;
        int s2;
        s = cyc;
        en = 1'b1;
        push_strobes(s, 5, 0, 2);
        wait_cyc(s + 2);
        clk_div = 8'd2;
        clk_div_valid = 1'b1;
        @(negedge clk);
        clk_div_valid = 1'b0;
        wait_cyc(s + 13);
        en = 1'b0;
        clk_div = 8'd1;
        clk_div_valid = 1'b1;
        @(negedge clk);
        clk_div_valid = 1'b0;
        wait_cyc(s + 15);
        n_tests++;
        if (exp_q.size() != 0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_first: outstanding=%0d running=%b, required 0 and 0",
                     exp_q.size(), running);
            exp_q.delete();
        end
        s2 = cyc;
        en = 1'b1;
        push_strobes(s2, 1, 0, 4);
        wait_cyc(s2 + 9);
        en = 1'b0;
        wait_cyc(s2 + 11);
        n_tests++;
        if (exp_q.size() != 0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_new_wins: outstanding=%0d running=%b, required 0 and 0",
                     exp_q.size(), running);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int s;
        int s2;
        s = cyc;
        clk_div = 8'd3;
        clk_div_valid = 1'b1;
        en = 1'b1;
        push_strobes(s, 3, 0, 1);
        @(negedge clk);
        clk_div_valid = 1'b0;
        wait_cyc(s + 6);
        n_tests++;
        if (spi_clk !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre_high: got %b, required 1", spi_clk);
        end
        #1;
        rstn = 1'b0;
        en = 1'b0;
        #1;
        n_tests++;
        if ({spi_clk, running, spi_rise, spi_fall} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b, required 0000",
                     {spi_clk, running, spi_rise, spi_fall});
        end
        wait_cyc(s + 8);
        rstn = 1'b1;
        wait_cyc(s + 9);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_missing: %0d strobes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        s2 = cyc;
        en = 1'b1;
        push_strobes(s2, 0, 0, 4);
        wait_cyc(s2 + 2);
        n_tests++;
        if (spi_clk !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_div0: got %b, required 1", spi_clk);
        end
        wait_cyc(s2 + 4);
        en = 1'b0;
        wait_cyc(s2 + 6);
        n_tests++;
        if (exp_q.size() != 0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_restart: outstanding=%0d running=%b, required 0 and 0",
                     exp_q.size(), running);
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int s;
        s = cyc;
        clk_div = 8'd3;
        clk_div_valid = 1'b1;
        en = 1'b1;
        push_strobes(s, 3, 0, 4);
        @(negedge clk);
        clk_div_valid = 1'b0;
        wait_cyc(s + 6);
        en = 1'b0;
        wait_cyc(s + 7);
        en = 1'b1;
        n_tests++;
        if ({running, spi_clk} !== 2'b11) begin
            n_fail++;
            $display("FAIL reen_drain: got running,spi_clk=%b, required 11", {running, spi_clk});
        end
        wait_cyc(s + 8);
        n_tests++;
        if (spi_clk !== 1'b1) begin
            n_fail++;
            $display("FAIL reen_full_high: got %b, required 1", spi_clk);
        end
        wait_cyc(s + 13);
        n_tests++;
        if ({running, spi_clk} !== 2'b11) begin
            n_fail++;
            $display("FAIL reen_continue: got running,spi_clk=%b, required 11", {running, spi_clk});
        end
        wait_cyc(s + 17);
        en = 1'b0;
        wait_cyc(s + 19);
        n_tests++;
        if (exp_q.size() != 0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL reen_end: outstanding=%0d running=%b, required 0 and 0",
                     exp_q.size(), running);
            exp_q.delete();
        end
    endtask

    initial begin
        rstn = 1'b0;
        en = 1'b0;
        clk_div = '0;
        clk_div_valid = 1'b0;
        test_reset();
        test_div0();
        test_div3();
        test_drain();
        test_div_update();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
